cd_multi: RTL and testbench

CD_MULTI -- requirements
Module: cd_multi

---
 rtl/cd_pkg.sv | 19 +
 rtl/cd_channel.sv | 43 ++++
 rtl/cd_multi.sv | 90 +++++++++
 tb/tb_cd_multi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cd_pkg.sv
// Shared definitions for the multi-channel clock divider: address map,
// reset defaults and config FSM encoding.
package cd_pkg;

  // Channel limits start at address 0; the enable mask sits right after them.
  localparam int CD_LIMIT_BASE = 0;
  localparam int CD_DEF_LIMIT  = 24;
  localparam logic [7:0] CD_DEF_EN = 8'hFF;

  typedef enum logic [0:0] {
    CD_IDLE  = 1'b0,
    CD_APPLY = 1'b1
  } cd_state_e;

  function automatic int cd_enable_addr(input int num_ch);
    return CD_LIMIT_BASE + num_ch;
  endfunction

endpackage

// File: rtl/cd_channel.sv
// One divided-clock channel: counter, toggle flop, limit register and the
// hook that lets a staged limit land on a terminal count.
module cd_channel
  import cd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] DEF_LIMIT = WIDTH'(CD_DEF_LIMIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] new_limit,
  output logic             tc,
  output logic             clk_out
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] limit;

  assign tc = en && (count == limit);

  // A load coinciding with tc swaps the limit after this half period completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      limit   <= DEF_LIMIT;
      clk_out <= 1'b0;
    end else begin
      if (load) limit <= new_limit;
      if (!en) begin
        count   <= '0;
        clk_out <= 1'b0;
      end else if (tc) begin
        count   <= '0;
        clk_out <= ~clk_out;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cd_multi.sv
// Multi-channel clock divider with a ready/valid configuration port.
// Optional macro CD_MULTI_TICK_EN adds a per-channel terminal-count pulse output.
module cd_multi
  import cd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter logic [WIDTH-1:0]  DEF_LIMIT = WIDTH'(CD_DEF_LIMIT),
  parameter logic [NUM_CH-1:0] DEF_EN    = CD_DEF_EN[NUM_CH-1:0],
  localparam int ADDR_W = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [WIDTH-1:0]  c_data,
  input  logic              c_valid,
  output logic              c_ready,
  output logic [NUM_CH-1:0] clk_out
`ifdef CD_MULTI_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick
`endif
);

  cd_state_e         state, state_nxt;
  logic [NUM_CH-1:0] en_q;
  logic [ADDR_W-1:0] pend_ch;
  logic [WIDTH-1:0]  pend_limit;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] applied;
  logic              accept, is_limit, is_enable;

  assign c_ready   = rst_n && (state == CD_IDLE);
  assign accept    = c_valid && c_ready;
  assign is_limit  = c_addr < ADDR_W'(cd_enable_addr(NUM_CH));
  assign is_enable = c_addr == ADDR_W'(cd_enable_addr(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CD_IDLE:  if (accept && is_limit) state_nxt = CD_APPLY;
      CD_APPLY: if (|applied)           state_nxt = CD_IDLE;
      default:  state_nxt = CD_IDLE;
    endcase
  end

  // Only one limit write can be outstanding since c_ready drops in APPLY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= DEF_EN;
      pend_ch    <= '0;
      pend_limit <= '0;
    end else begin
      if (accept && is_limit) begin
        pend_ch    <= c_addr - ADDR_W'(CD_LIMIT_BASE);
        pend_limit <= c_data;
      end
      if (accept && is_enable) en_q <= c_data[NUM_CH-1:0];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // A disabled target has no terminal count to wait for, so it loads at once.
    assign applied[i] = (state == CD_APPLY) && (pend_ch == ADDR_W'(i)) &&
                        (tc[i] || !en_q[i]);

    cd_channel #(
      .WIDTH     (WIDTH),
      .DEF_LIMIT (DEF_LIMIT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_q[i]),
      .load      (applied[i]),
      .new_limit (pend_limit),
      .tc        (tc[i]),
      .clk_out   (clk_out[i])
    );
  end

`ifdef CD_MULTI_TICK_EN
  assign tick = tc;
`endif

endmodule

// File: tb/tb_cd_multi.sv
// Scoreboard bench for cd_multi: expected clk_out edges are queued per channel
// and popped by a monitor whenever a watched channel changes level.
module tb_cd_multi;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] c_addr;
  logic [WIDTH-1:0]  c_data;
  logic              c_valid;
  logic              c_ready;
  logic [NUM_CH-1:0] clk_out;
`ifdef CD_MULTI_TICK_EN
  logic [NUM_CH-1:0] tick;
`endif

  always #5 clk = ~clk;

  cd_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .c_addr  (c_addr),
    .c_data  (c_data),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .clk_out (clk_out)
`ifdef CD_MULTI_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  ev_t               exp_q[NUM_CH][$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc   = 0;
  logic [NUM_CH-1:0] watch = '0;
  logic [NUM_CH-1:0] prev  = '0;

  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int ch, input int t, input logic v);
    ev_t e;
    e.cyc = t;
    e.val = v;
    exp_q[ch].push_back(e);
  endtask

  task automatic push_run(input int ch, input int start, input int step,
                          input logic v0, input int stop);
    logic v;
    v = v0;
    for (int t = start; t <= stop; t += step) begin
      push_ev(ch, t, v);
      v = ~v;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drives one config write from a negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                               input string name);
    checkOutput({name, " c_ready before write"}, int'(c_ready), 1);
    c_addr  = a;
    c_data  = d;
    c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
  endtask

  // Monitor: cycle count since reset release, edge checking on watched channels.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) cyc = 0;
      else        cyc++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (watch[ch] && (clk_out[ch] !== prev[ch])) begin
          if (exp_q[ch].size() == 0) begin
            checkOutput($sformatf("ch%0d unexpected edge cycle", ch), cyc, -1);
          end else begin
            ev_t e;
            e = exp_q[ch].pop_front();
            checkOutput($sformatf("ch%0d edge cycle", ch), cyc, e.cyc);
            checkOutput($sformatf("ch%0d edge level", ch), int'(clk_out[ch]), int'(e.val));
          end
        end
      end
      prev = clk_out;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    c_addr  = '0;
    c_data  = '0;
    c_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset clk_out", int'(clk_out), 0);
    checkOutput("reset c_ready", int'(c_ready), 0);

    // Reset release: default limit 24 gives rises at 25, 75 and falls at 50, 100.
    @(negedge clk);
    rst_n = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) push_run(ch, 25, 25, 1'b1, 100);
    watch = '1;
    #1;
    checkOutput("c_ready after release", int'(c_ready), 1);

    // Mid-period write: ch1 count is 10 at accept edge 111, loads at edge 125.
    wait_cyc(110);
    push_ev(0, 125, 1'b1);
    push_ev(1, 125, 1'b1);
    push_ev(2, 125, 1'b1);
    push_ev(3, 125, 1'b1);
    push_run(1, 130, 5, 1'b0, 240);
    applyStimulus(3'd1, 16'd4, "ch1 limit write");
    checkOutput("c_ready in APPLY after ch1 write", int'(c_ready), 0);
    wait_cyc(124);
    checkOutput("c_ready before ch1 load", int'(c_ready), 0);
    wait_cyc(125);
    checkOutput("c_ready after ch1 load", int'(c_ready), 1);

    // Enable mask 1011 accepted at 126: ch2 drops at 127 and stays low.
    push_ev(2, 127, 1'b0);
    push_ev(0, 150, 1'b0);
    push_run(3, 150, 25, 1'b0, 225);
    applyStimulus(3'd4, 16'h000B, "mask 1011 write");
    checkOutput("c_ready after mask write", int'(c_ready), 1);

    // Limit 0 to disabled ch2 at 131 loads at 132; re-enable at 141 toggles from 142.
    wait_cyc(130);
    push_run(2, 142, 1, 1'b1, 240);
    applyStimulus(3'd2, 16'd0, "ch2 disabled limit write");
    checkOutput("c_ready in APPLY after ch2 write", int'(c_ready), 0);
    wait_cyc(132);
    checkOutput("c_ready after ch2 disabled load", int'(c_ready), 1);
    wait_cyc(140);
    applyStimulus(3'd4, 16'h000F, "mask 1111 write");

    // Coincident write on ch0 terminal count 175: old limit to 200, then period 20.
    wait_cyc(174);
    push_ev(0, 175, 1'b1);
    push_ev(0, 200, 1'b0);
    push_run(0, 210, 10, 1'b1, 240);
    applyStimulus(3'd0, 16'd9, "ch0 coincident write");
    checkOutput("c_ready in APPLY after ch0 write", int'(c_ready), 0);
    wait_cyc(199);
    checkOutput("c_ready before ch0 load", int'(c_ready), 0);
    wait_cyc(200);
    checkOutput("c_ready after ch0 load", int'(c_ready), 1);

    // Unmapped address is accepted and has no effect.
    wait_cyc(204);
    applyStimulus(3'd7, 16'd0, "unmapped write");
    checkOutput("c_ready after unmapped write", int'(c_ready), 1);

    // Reset mid-APPLY: pending limit 2 for ch3 must be discarded.
    wait_cyc(240);
    watch = '0;
    applyStimulus(3'd3, 16'd2, "ch3 write before reset");
    checkOutput("c_ready in APPLY before reset", int'(c_ready), 0);
    wait_cyc(242);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-APPLY reset clk_out", int'(clk_out), 0);
    checkOutput("mid-APPLY reset c_ready", int'(c_ready), 0);
    repeat (2) @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++) checkOutput($sformatf("ch%0d queue drained before reset", ch),
                                                    exp_q[ch].size(), 0);
    rst_n = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      push_ev(ch, 25, 1'b1);
      push_ev(ch, 50, 1'b0);
    end
    watch = '1;
    #1;
    checkOutput("c_ready after second release", int'(c_ready), 1);
    wait_cyc(60);

    for (int ch = 0; ch < NUM_CH; ch++) checkOutput($sformatf("ch%0d missing edges", ch),
                                                    exp_q[ch].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
